// File: rtl/mxu_accum_if.sv
// Handshake and data bundle for the sequential DIM x DIM matrix multiplier.
// The slave side is the multiplier. The master side is the feeder/consumer.
interface mxu_accum_if #(
    parameter int DIM       = 4,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 32
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]        in0;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]        in1;
    logic                                      acc_en;
    logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]    out;
    logic                                      out_valid;
    logic                                      out_ready;
    logic                                      busy;

    modport slave (
        input  in_valid, in0, in1, acc_en, out_ready,
        output in_ready, out, out_valid, busy
    );

    modport master (
        output in_valid, in0, in1, acc_en, out_ready,
        input  in_ready, out, out_valid, busy
    );
endinterface

// File: rtl/mxu_accum.sv
// Sequential DIM x DIM matrix multiply-accumulate: Y = A*B or Y += A*B.
// One k-slice of the inner product is folded into every accumulator per cycle,
// so a job takes DIM compute cycles between the input and output handshakes.
module mxu_accum #(
    parameter int DIM       = 4,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    mxu_accum_if.slave  bus
);
    localparam int KW = $clog2(DIM);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                                  state;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]      a_lat;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]      b_lat;
    logic                                    acc_en_lat;
    logic [KW-1:0]                           k;
    logic [DIM-1:0][DIM-1:0][OUT_WIDTH-1:0]  acc;
    logic [OUT_WIDTH-1:0]                    acc_next [DIM][DIM];
    logic                                    in_rdy;
    logic                                    out_vld;
    logic                                    busy_st;

    // Widen an operand to the accumulator width; the top bits follow the mode.
    function automatic logic [OUT_WIDTH-1:0] ext(input logic [WIDTH-1:0] v);
        if (SIGNED != 0)
            ext = {{(OUT_WIDTH-WIDTH){v[WIDTH-1]}}, v};
        else
            ext = {{(OUT_WIDTH-WIDTH){1'b0}}, v};
    endfunction

    // One multiply-add lane per output element; all lanes share the k-slice.
    genvar gi, gj;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_row
            for (gj = 0; gj < DIM; gj++) begin : g_col
                logic [OUT_WIDTH-1:0] prod;
                logic [OUT_WIDTH-1:0] base;
                // Product truncates to OUT_WIDTH, giving wrap-around arithmetic.
                assign prod = ext(a_lat[gi][k]) * ext(b_lat[k][gj]);
                // First slice of a non-accumulating job starts from zero.
                assign base = (k == '0 && !acc_en_lat) ? '0 : acc[gi][gj];
                assign acc_next[gi][gj] = base + prod;
            end
        end
    endgenerate

    // Job sequencing, operand capture, accumulator update and registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            a_lat      <= '0;
            b_lat      <= '0;
            acc_en_lat <= 1'b0;
            k          <= '0;
            acc        <= '0;
            in_rdy     <= 1'b1;
            out_vld    <= 1'b0;
            busy_st    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_lat      <= bus.in0;
                        b_lat      <= bus.in1;
                        acc_en_lat <= bus.acc_en;
                        k          <= '0;
                        in_rdy     <= 1'b0;
                        busy_st    <= 1'b1;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int r = 0; r < DIM; r++)
                        for (int c = 0; c < DIM; c++)
                            acc[r][c] <= acc_next[r][c];
                    if (k == KW'(DIM-1)) begin
                        out_vld <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        busy_st <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    in_rdy  <= 1'b1;
                    out_vld <= 1'b0;
                    busy_st <= 1'b0;
                end
            endcase
        end
    end

    // The result bus is the accumulator itself, so it holds after the handshake.
    assign bus.out       = acc;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.busy      = busy_st;
endmodule

// File: tb/tb_mxu_accum.sv
// Bench for mxu_accum: three instances (unsigned/32, signed/32, unsigned/16)
// share one stimulus stream and are checked against a plain-arithmetic model.
module tb_mxu_accum;
    typedef logic [3:0][3:0][7:0] mat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    mat_t a_drv = '0;
    mat_t b_drv = '0;
    logic valid_drv = 1'b0;
    logic en_drv = 1'b0;
    logic ordy_drv = 1'b1;

    int errors = 0;
    int checks = 0;
    int jobs = 0;

    longint exp_u [4][4];
    longint exp_s [4][4];
    longint exp_w [4][4];

    always #5 clk = ~clk;

    mxu_accum_if #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32)) bus_u ();
    mxu_accum_if #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32)) bus_s ();
    mxu_accum_if #(.DIM(4), .WIDTH(8), .OUT_WIDTH(16)) bus_w ();

    assign bus_u.in_valid = valid_drv; assign bus_u.in0 = a_drv; assign bus_u.in1 = b_drv;
    assign bus_u.acc_en = en_drv;      assign bus_u.out_ready = ordy_drv;
    assign bus_s.in_valid = valid_drv; assign bus_s.in0 = a_drv; assign bus_s.in1 = b_drv;
    assign bus_s.acc_en = en_drv;      assign bus_s.out_ready = ordy_drv;
    assign bus_w.in_valid = valid_drv; assign bus_w.in0 = a_drv; assign bus_w.in1 = b_drv;
    assign bus_w.acc_en = en_drv;      assign bus_w.out_ready = ordy_drv;

    mxu_accum #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32), .SIGNED(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus_u));
    mxu_accum #(.DIM(4), .WIDTH(8), .OUT_WIDTH(32), .SIGNED(1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .bus(bus_s));
    mxu_accum #(.DIM(4), .WIDTH(8), .OUT_WIDTH(16), .SIGNED(0)) u_dut_w (
        .clk(clk), .reset_n(reset_n), .bus(bus_w));

    function automatic mat_t fill(input logic [7:0] v);
        mat_t m;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = (r == c) ? 8'd1 : 8'd0;
        return m;
    endfunction

    function automatic mat_t rnd();
        mat_t m;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m[r][c] = 8'($urandom);
        return m;
    endfunction

    // Reference: whole inner product at once, then optional add and wrap.
    task automatic model_job(input mat_t a, input mat_t b, input logic en);
        longint su, ss;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                su = 0; ss = 0;
                for (int k = 0; k < 4; k++) begin
                    su += longint'(a[r][k]) * longint'(b[k][c]);
                    ss += longint'($signed(a[r][k])) * longint'($signed(b[k][c]));
                end
                exp_u[r][c] = ((en ? exp_u[r][c] : 64'd0) + su) & 64'hFFFF_FFFF;
                exp_s[r][c] = ((en ? exp_s[r][c] : 64'd0) + ss) & 64'hFFFF_FFFF;
                exp_w[r][c] = ((en ? exp_w[r][c] : 64'd0) + su) & 64'hFFFF;
            end
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
            exp_u[r][c] = 0; exp_s[r][c] = 0; exp_w[r][c] = 0;
        end
    endtask

    // Index of first element differing from the model, or -1.
    function automatic int diff_u();
        for (int i = 0; i < 16; i++)
            if (bus_u.out[i/4][i%4] !== 32'(exp_u[i/4][i%4])) return i;
        return -1;
    endfunction
    function automatic int diff_s();
        for (int i = 0; i < 16; i++)
            if (bus_s.out[i/4][i%4] !== 32'(exp_s[i/4][i%4])) return i;
        return -1;
    endfunction
    function automatic int diff_w();
        for (int i = 0; i < 16; i++)
            if (bus_w.out[i/4][i%4] !== 16'(exp_w[i/4][i%4])) return i;
        return -1;
    endfunction

    // Present one job while the block is idle; returns at the negedge after accept.
    task automatic send(input mat_t a, input mat_t b, input logic en);
        @(negedge clk);
        a_drv = a; b_drv = b; en_drv = en; valid_drv = 1'b1;
        model_job(a, b, en);
        @(negedge clk);
        valid_drv = 1'b0;
    endtask

    // Bounded wait for out_valid; counts cycles where ready/busy looked wrong.
    task automatic wait_done(output int cycles, output int bad_flags);
        cycles = 0; bad_flags = 0;
        while (bus_u.out_valid !== 1'b1 && cycles < 40) begin
            if (bus_u.in_ready !== 1'b0 || bus_u.busy !== 1'b1) bad_flags++;
            @(negedge clk);
            cycles++;
        end
        jobs++;
        checks++;
        if (bus_u.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, want 1", bus_u.out_valid, cycles);
        end
        $display("job %0d: latency=%0d y00=%h", jobs, cycles, bus_u.out[0][0]);
    endtask

    // Compare all three instances against the model at the current negedge.
    task automatic check_models(input string tag);
        int d;
        d = diff_u(); checks++;
        if (d !== -1) begin errors++;
            $display("FAIL %s_u: Y[%0d] got %h want %h", tag, d, bus_u.out[d/4][d%4], 32'(exp_u[d/4][d%4])); end
        d = diff_s(); checks++;
        if (d !== -1) begin errors++;
            $display("FAIL %s_s: Y[%0d] got %h want %h", tag, d, bus_s.out[d/4][d%4], 32'(exp_s[d/4][d%4])); end
        d = diff_w(); checks++;
        if (d !== -1) begin errors++;
            $display("FAIL %s_w: Y[%0d] got %h want %h", tag, d, bus_w.out[d/4][d%4], 16'(exp_w[d/4][d%4])); end
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_u.in_ready, bus_u.out_valid, bus_u.busy} !== 3'b100) begin errors++;
            $display("FAIL reset_flags: rdy/vld/busy got %b want 100", {bus_u.in_ready, bus_u.out_valid, bus_u.busy}); end
        checks++;
        if (bus_u.out !== '0) begin errors++;
            $display("FAIL reset_out: got %h want 0", bus_u.out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_u.in_ready, bus_u.busy} !== 2'b10) begin errors++;
            $display("FAIL idle_flags: rdy/busy got %b want 10", {bus_u.in_ready, bus_u.busy}); end
    endtask

    task automatic test_defaults();
        int cyc, bad;
        send(fill(8'd1), fill(8'd2), 1'b0);
        wait_done(cyc, bad);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL latency: got %0d want 4", cyc); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL compute_flags: bad cycles %0d want 0", bad); end
        checks++;
        if (bus_u.out[2][1] !== 32'd8) begin errors++; $display("FAIL defaults_y: got %0d want 8", bus_u.out[2][1]); end
        check_models("defaults");
        @(negedge clk);
        checks++;
        if ({bus_u.out_valid, bus_u.in_ready} !== 2'b01) begin errors++;
            $display("FAIL release: vld/rdy got %b want 01", {bus_u.out_valid, bus_u.in_ready}); end
    endtask

    task automatic test_signed();
        int cyc, bad;
        send(fill(8'hFF), fill(8'd3), 1'b0);
        wait_done(cyc, bad);
        checks++;
        if (bus_s.out[1][2] !== 32'hFFFF_FFF4) begin errors++;
            $display("FAIL signed_y: got %h want fffffff4", bus_s.out[1][2]); end
        checks++;
        if (bus_u.out[3][0] !== 32'd3060) begin errors++;
            $display("FAIL unsigned_y: got %0d want 3060", bus_u.out[3][0]); end
        check_models("signed");
    endtask

    task automatic test_accumulate();
        int cyc, bad;
        logic [31:0] want [3];
        logic        ens  [3];
        want = '{32'd5, 32'd10, 32'd5};
        ens  = '{1'b0, 1'b1, 1'b0};
        for (int j = 0; j < 3; j++) begin
            send(ident(), fill(8'd5), ens[j]);
            wait_done(cyc, bad);
            checks++;
            if (bus_u.out[j][3] !== want[j]) begin errors++;
                $display("FAIL accumulate_%0d: got %0d want %0d", j, bus_u.out[j][3], want[j]); end
            check_models("accumulate");
        end
    endtask

    task automatic test_backpressure();
        int cyc, bad;
        logic [3:0][3:0][31:0] snap;
        @(negedge clk);
        ordy_drv = 1'b0;
        send(rnd(), rnd(), 1'b0);
        wait_done(cyc, bad);
        check_models("bp_first");
        snap = bus_u.out;
        for (int i = 0; i < 10; i++) begin
            valid_drv = (i == 3);
            if (i == 3) a_drv = fill(8'd9);
            @(negedge clk);
            checks++;
            if ({bus_u.out_valid, bus_u.in_ready} !== 2'b10) begin errors++;
                $display("FAIL bp_hold_%0d: vld/rdy got %b want 10", i, {bus_u.out_valid, bus_u.in_ready}); end
            checks++;
            if (bus_u.out !== snap) begin errors++;
                $display("FAIL bp_stable_%0d: out changed to %h", i, bus_u.out[0][0]); end
        end
        valid_drv = 1'b0;
        ordy_drv = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_u.out_valid, bus_u.in_ready, bus_u.busy} !== 3'b010) begin errors++;
            $display("FAIL bp_release: vld/rdy/busy got %b want 010", {bus_u.out_valid, bus_u.in_ready, bus_u.busy}); end
        check_models("bp_after");
    endtask

    task automatic test_reset_mid();
        int cyc, bad;
        send(rnd(), rnd(), 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_u.out_valid, bus_u.in_ready, bus_u.busy} !== 3'b010) begin errors++;
            $display("FAIL abort_flags: vld/rdy/busy got %b want 010", {bus_u.out_valid, bus_u.in_ready, bus_u.busy}); end
        checks++;
        if (bus_u.out !== '0) begin errors++; $display("FAIL abort_out: got %h want 0", bus_u.out[0][0]); end
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        send(fill(8'd1), fill(8'd1), 1'b1);
        wait_done(cyc, bad);
        checks++;
        if (bus_u.out[3][3] !== 32'd4) begin errors++; $display("FAIL after_abort: got %0d want 4", bus_u.out[3][3]); end
        check_models("after_abort");
    endtask

    task automatic test_wrap();
        int cyc, bad, nbad;
        mat_t b;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) b[r][c] = 8'(16*r + c);
        send(ident(), b, 1'b0);
        wait_done(cyc, bad);
        nbad = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
            if (bus_u.out[r][c] !== 32'(b[r][c])) nbad++;
        checks++;
        if (nbad !== 0) begin errors++; $display("FAIL identity: %0d elements differ, want 0", nbad); end
        check_models("identity");
        send(fill(8'hFF), fill(8'hFF), 1'b0);
        wait_done(cyc, bad);
        send(fill(8'hFF), fill(8'hFF), 1'b1);
        wait_done(cyc, bad);
        checks++;
        if (bus_w.out[0][3] !== 16'hF008) begin errors++; $display("FAIL wrap16: got %h want f008", bus_w.out[0][3]); end
        check_models("wrap");
    endtask

    task automatic test_back_to_back();
        int cyc, bad;
        for (int j = 0; j < 16; j++) begin
            send(rnd(), rnd(), 1'($urandom_range(0, 1)));
            wait_done(cyc, bad);
            checks++;
            if (cyc !== 4 || bad !== 0) begin errors++;
                $display("FAIL b2b_timing_%0d: latency %0d bad %0d want 4/0", j, cyc, bad); end
            check_models("b2b");
            if ($urandom_range(0, 1) == 1) begin
                ordy_drv = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                ordy_drv = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_signed();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
